// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Arbiter FSM encoding; at most one memory access is ever outstanding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // Access-size codes carried on d_size / mem_size.
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data ports, with fetch anti-starvation.
module mem_arb_prio #(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_idle,
    input  logic i_if_req,
    input  logic i_d_req,
    input  logic i_flush,
    output logic o_if_gnt,
    output logic o_d_gnt
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_fetch_ok;
    logic             w_data_ok;
    logic             w_starved;

    // Data normally wins; a fetch that has waited STARVE_MAX data grants wins instead.
    always_comb begin
        w_fetch_ok = i_idle && !i_reset && i_if_req && !i_flush;
        w_data_ok  = i_idle && !i_reset && i_d_req;
        w_starved  = (r_starve_cnt == MAX_C);
        o_if_gnt   = w_fetch_ok && (!w_data_ok || w_starved);
        o_d_gnt    = w_data_ok && !(w_fetch_ok && w_starved);
    end

    // Count data grants taken while fetch is waiting; saturate, clear when fetch is served.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_starve_cnt <= '0;
        end else if (o_if_gnt) begin
            r_starve_cnt <= '0;
        end else if (o_d_gnt && i_if_req && (r_starve_cnt != MAX_C)) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_un,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    output logic              mem_un,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    state_t            r_state;
    logic              r_mem_req;
    logic              r_we;
    logic              r_un;
    logic              r_kill;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_if_rvalid;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_idle;

    assign w_idle = (r_state == IDLE);

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_prio (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_idle   (w_idle),
        .i_if_req (if_req),
        .i_d_req  (d_req),
        .i_flush  (flush),
        .o_if_gnt (if_gnt),
        .o_d_gnt  (d_gnt)
    );

    assign mem_req   = r_mem_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_size  = r_size;
    assign mem_un    = r_un;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;

    // Arbiter FSM: capture the granted request, hold it on the memory port, return the response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_we        <= 1'b0;
            r_un        <= 1'b0;
            r_kill      <= 1'b0;
            r_size      <= BYTE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (if_gnt) begin
                        r_state   <= BUSY_I;
                        r_mem_req <= 1'b1;
                        r_we      <= 1'b0;
                        r_addr    <= if_addr;
                        r_wdata   <= '0;
                        r_size    <= WORD;
                        r_un      <= 1'b0;
                    end else if (d_gnt) begin
                        r_state   <= BUSY_D;
                        r_mem_req <= 1'b1;
                        r_we      <= d_we;
                        r_addr    <= d_addr;
                        r_wdata   <= d_wdata;
                        r_size    <= d_size;
                        r_un      <= d_un;
                    end
                end
                BUSY_I: begin
                    // A redirect anywhere in the fetch lifetime makes its data stale.
                    if (flush) begin
                        r_kill <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_state     <= IDLE;
                        r_mem_req   <= 1'b0;
                        r_kill      <= 1'b0;
                        r_if_rvalid <= !(r_kill || flush);
                        r_if_rdata  <= mem_rdata;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        r_state    <= IDLE;
                        r_mem_req  <= 1'b0;
                        r_we       <= 1'b0;
                        r_d_rvalid <= 1'b1;
                        r_d_rdata  <= r_we ? '0 : mem_rdata;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                    r_we      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_un;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_un;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t m_exp;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_size    (d_size),
        .d_un      (d_un),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_size  (mem_size),
        .mem_un    (mem_un),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Each cycle: inputs change just after the falling edge, checks follow 1 time unit later.
    task automatic next_cycle();
        @(negedge clock);
        #1;
    endtask

    // Serve the access granted in the previous cycle: lat cycles of waiting, then mem_ack.
    task automatic serve(input int lat, input logic [31:0] rd, input logic is_d,
                         input logic [31:0] exp_data, input logic push);
        for (int i = 0; i < lat; i++) begin
            #1;
            chk("mem_req_busy", mem_req, 1);
            next_cycle();
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        #1;
        chk("mem_req_ack", mem_req, 1);
        if (push) sb.push_back('{is_d: is_d, data: exp_data});
        next_cycle();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        chk("mem_req_idle", mem_req, 0);
    endtask

    // Completion monitor: every rvalid must match the oldest expected response.
    always @(negedge clock) begin
        if (!reset && (if_rvalid || d_rvalid)) begin
            chk("rvalid_excl", {63'd0, if_rvalid & d_rvalid}, 0);
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 1, 0);
            end else begin
                m_exp = sb.pop_front();
                chk("rvalid_port", {63'd0, d_rvalid}, {63'd0, m_exp.is_d});
                chk("rdata", d_rvalid ? d_rdata : if_rdata, m_exp.data);
            end
        end
    end

    initial begin
        reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_size = 0; d_un = 0; flush = 0; mem_ack = 0; mem_rdata = 0;

        // Reset state, with requests pending that must not be granted.
        next_cycle();
        if_req = 1; d_req = 1;
        #1;
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);

        // Single fetch, granted in the first cycle after reset release.
        next_cycle();
        reset = 0; d_req = 0; if_req = 1; if_addr = 32'h0100_0000;
        #1;
        chk("f1_if_gnt", if_gnt, 1);
        chk("f1_mem_req_c0", mem_req, 0);
        next_cycle();
        if_req = 0;
        #1;
        chk("f1_mem_addr", mem_addr, 32'h0100_0000);
        chk("f1_mem_we", mem_we, 0);
        serve(2, 32'h0000_0013, 0, 32'h0000_0013, 1);
        chk("f1_if_rvalid", if_rvalid, 1);
        chk("f1_if_rdata", if_rdata, 32'h0000_0013);
        next_cycle();
        chk("f1_if_rvalid_pulse", if_rvalid, 0);

        // Contention: data load wins, fetch granted in the next IDLE cycle.
        next_cycle();
        if_req = 1; if_addr = 32'h0100_0200;
        d_req = 1; d_we = 0; d_addr = 32'h0100_0100; d_size = 2'd2;
        #1;
        chk("ct_d_gnt", d_gnt, 1);
        chk("ct_if_gnt", if_gnt, 0);
        next_cycle();
        d_req = 0;
        #1;
        chk("ct_busy_if_gnt", if_gnt, 0);
        chk("ct_mem_addr", mem_addr, 32'h0100_0100);
        serve(1, 32'h0000_0055, 1, 32'h0000_0055, 1);
        #1;
        chk("ct_if_gnt_next", if_gnt, 1);
        next_cycle();
        if_req = 0;
        #1;
        chk("ct_fetch_addr", mem_addr, 32'h0100_0200);
        serve(1, 32'h0000_0077, 0, 32'h0000_0077, 1);

        // Starvation: three data grants while fetch waits, then fetch wins.
        next_cycle();
        if_req = 1; if_addr = 32'h0100_0300;
        d_req = 1; d_addr = 32'h0100_0400; d_we = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("sv_d_gnt", d_gnt, 1);
            chk("sv_if_gnt", if_gnt, 0);
            chk("sv_cnt", dut.u_prio.r_starve_cnt, k);
            next_cycle();
            d_req = 0;
            serve(0, 32'h100 + k, 1, 32'h100 + k, 1);
            d_req = 1;
        end
        #1;
        chk("sv_cnt_max", dut.u_prio.r_starve_cnt, 3);
        chk("sv_if_wins", if_gnt, 1);
        chk("sv_d_loses", d_gnt, 0);
        next_cycle();
        if_req = 0;
        #1;
        chk("sv_cnt_clr", dut.u_prio.r_starve_cnt, 0);
        chk("sv_busy_d_gnt", d_gnt, 0);
        serve(0, 32'h0000_0200, 0, 32'h0000_0200, 1);
        #1;
        chk("sv_d_after", d_gnt, 1);
        next_cycle();
        d_req = 0;
        serve(0, 32'h0000_0300, 1, 32'h0000_0300, 1);
        chk("sv_cnt_no_if", dut.u_prio.r_starve_cnt, 0);

        // Flush kills an in-flight fetch.
        next_cycle();
        if_req = 1; if_addr = 32'h0100_0500;
        #1;
        chk("fl_if_gnt", if_gnt, 1);
        next_cycle();
        if_req = 0;
        #1;
        chk("fl_mem_req_c1", mem_req, 1);
        next_cycle();
        flush = 1;
        #1;
        chk("fl_mem_req_c2", mem_req, 1);
        next_cycle();
        flush = 0; mem_ack = 1; mem_rdata = 32'h0000_DEAD;
        next_cycle();
        mem_ack = 0; mem_rdata = 0; flush = 1; if_req = 1;
        #1;
        chk("fl_no_rvalid", if_rvalid, 0);
        chk("fl_gnt_blocked", if_gnt, 0);
        flush = 0;
        #1;
        chk("fl_idle_gnt", if_gnt, 1);
        next_cycle();
        if_req = 0;
        serve(1, 32'h0000_1234, 0, 32'h0000_1234, 1);

        // Stray mem_ack while idle is ignored.
        mem_ack = 1; mem_rdata = 32'h0000_0BAD;
        next_cycle();
        mem_ack = 0; mem_rdata = 0;
        #1;
        chk("stray_mem_req", mem_req, 0);
        chk("stray_rvalid", {if_rvalid, d_rvalid}, 0);

        // Byte store, with flush active during it (no effect on data).
        next_cycle();
        d_req = 1; d_we = 1; d_size = 2'd0; d_wdata = 32'h0000_00AB; d_addr = 32'h0000_2001;
        #1;
        chk("st_d_gnt", d_gnt, 1);
        next_cycle();
        d_req = 0; d_we = 0; d_wdata = 0; d_size = 2'd2; flush = 1;
        #1;
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_size", mem_size, 0);
        chk("st_mem_wdata", mem_wdata, 32'h0000_00AB);
        chk("st_mem_addr", mem_addr, 32'h0000_2001);
        serve(1, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1);
        flush = 0;
        chk("st_mem_we_idle", mem_we, 0);
        chk("st_d_rvalid", d_rvalid, 1);

        // Reset in BUSY_D abandons the access; late ack ignored.
        next_cycle();
        d_req = 1; d_we = 0; d_addr = 32'h0000_3000; d_size = 2'd2;
        #1;
        chk("rb_d_gnt", d_gnt, 1);
        next_cycle();
        d_req = 0;
        #1;
        chk("rb_mem_req", mem_req, 1);
        reset = 1;
        #1;
        chk("rb_async_mem_req", mem_req, 0);
        chk("rb_async_mem_addr", mem_addr, 0);
        next_cycle();
        reset = 0; mem_ack = 1; mem_rdata = 32'h0000_0BAD;
        #1;
        chk("rb_late_ack_mem_req", mem_req, 0);
        next_cycle();
        mem_ack = 0; mem_rdata = 0;
        #1;
        chk("rb_no_d_rvalid", d_rvalid, 0);
        next_cycle();
        chk("sb_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
